microcode_sequencer: RTL

MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

---
 rtl/mcseq_pkg.sv | 30 +++
 rtl/nmi_edge_detect.sv | 38 +++
 rtl/microcode_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mcseq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcseq_pkg
// Description : Shared types and constants for the microcode sequencer:
//               state encoding, INT_KIND codes, fetch address, BRK opcode.
// Revision    : 1.0 - initial release
// ============================================================================
package mcseq_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_RESET_SEQ = 2'd0,
      ST_FETCH     = 2'd1,
      ST_EXEC      = 2'd2
   } state_t;

   // INT_KIND codes
   localparam logic [1:0] INT_NONE  = 2'b00;  // normal opcode or BRK
   localparam logic [1:0] INT_IRQ   = 2'b01;
   localparam logic [1:0] INT_NMI   = 2'b10;
   localparam logic [1:0] INT_RESET = 2'b11;

   // Microcode address presented while fetching an opcode
   localparam logic [12:0] FETCH_ADDR = 13'h1000;

   // Opcode forced into IR when an interrupt replaces the fetched opcode
   localparam logic [7:0] BRK_OPCODE = 8'h00;

endpackage : mcseq_pkg
`default_nettype wire

// File: rtl/nmi_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : nmi_edge_detect
// Description : Falling-edge detector for the active-low NMI line. Keeps a
//               one-cycle sample of NMI and a pending flag that is set on a
//               1->0 transition and cleared when the sequencer accepts it.
//               An edge seen in the same cycle as the clear is absorbed by
//               the NMI being accepted and is not latched again.
// Revision    : 1.0 - initial release
// ============================================================================
module nmi_edge_detect
   import mcseq_pkg::*;
(
   input  logic clk,
   input  logic RST,
   input  logic NMI,
   input  logic clear,
   output logic pending
);

   logic r_sample;
   logic r_pending;

   // Sample NMI every cycle (independent of RDY) and track a pending edge
   always_ff @(posedge clk) begin
      if (!RST) begin
         r_sample  <= 1'b1;
         r_pending <= 1'b0;
      end else begin
         r_sample  <= NMI;
         r_pending <= clear ? 1'b0 : (r_pending | (r_sample & ~NMI));
      end
   end

   assign pending = r_pending;

endmodule : nmi_edge_detect
`default_nettype wire

// File: rtl/microcode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : microcode_sequencer
// Description : Opcode fetch / microstep sequencer. Walks RESET_SEQ -> EXEC
//               -> FETCH -> EXEC ..., producing the microcode ROM address
//               {1'b0, IR, STEP} during execution and FETCH_ADDR during
//               opcode fetch. Interrupts replace the fetched opcode with BRK.
//               Optional feature macro: MICROCODE_SEQUENCER_NMI_EN enables
//               the NMI falling-edge detector and NMI acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module microcode_sequencer
   import mcseq_pkg::*;
#(
   parameter int STEP_W = 4,
   parameter int IR_W   = 8
)(
   input  logic                     clk,
   input  logic                     RST,
   input  logic                     RDY,
   input  logic [IR_W-1:0]          D_IN,
   input  logic                     MC_END,
   input  logic                     IRQ,
   input  logic                     NMI,
   input  logic                     I_FLAG,
   output logic [IR_W+STEP_W:0]     MC_ADDR,
   output logic                     SYNC,
   output logic [IR_W-1:0]          IR,
   output logic [STEP_W-1:0]        STEP,
   output logic [1:0]               INT_KIND,
   output logic                     INT_ACK,
   output logic                     ILLEGAL
);

   localparam int                c_ADDR_W   = IR_W + STEP_W + 1;
   localparam logic [STEP_W-1:0] c_STEP_MAX = '1;
   localparam logic [STEP_W-1:0] c_STEP_ONE = STEP_W'(1);

   state_t              r_state,    w_state_nxt;
   logic [IR_W-1:0]     r_ir,       w_ir_nxt;
   logic [STEP_W-1:0]   r_step,     w_step_nxt;
   logic [1:0]          r_int_kind, w_int_kind_nxt;
   logic                r_int_ack,  w_int_ack_nxt;
   logic                r_illegal,  w_illegal_nxt;
   logic                w_nmi_pending;
   logic                w_nmi_clear;
   logic [c_ADDR_W-1:0] w_fetch_addr;

   // Fetch address: package constant for the standard geometry, otherwise
   // the same "top bit set" pattern scaled to the configured width.
   generate
      if (c_ADDR_W == 13) begin : g_fetch_addr_pkg
         assign w_fetch_addr = FETCH_ADDR;
      end else begin : g_fetch_addr_scaled
         assign w_fetch_addr = {1'b1, {(c_ADDR_W-1){1'b0}}};
      end
   endgenerate

`ifdef MICROCODE_SEQUENCER_NMI_EN
   nmi_edge_detect u_nmi_edge_detect (
      .clk     (clk),
      .RST     (RST),
      .NMI     (NMI),
      .clear   (w_nmi_clear),
      .pending (w_nmi_pending)
   );
`else
   // NMI support compiled out: the line is ignored, nothing is ever pending
   logic w_nmi_unused;
   assign w_nmi_unused  = NMI ^ w_nmi_clear;
   assign w_nmi_pending = 1'b0;
`endif

   // State register; reset abandons any instruction regardless of RDY
   always_ff @(posedge clk) begin
      if (!RST) begin
         r_state    <= ST_RESET_SEQ;
         r_ir       <= IR_W'(BRK_OPCODE);
         r_step     <= '0;
         r_int_kind <= INT_RESET;
         r_int_ack  <= 1'b0;
         r_illegal  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ir       <= w_ir_nxt;
         r_step     <= w_step_nxt;
         r_int_kind <= w_int_kind_nxt;
         r_int_ack  <= w_int_ack_nxt;
         r_illegal  <= w_illegal_nxt;
      end
   end

   // Next-state decode; with RDY low everything holds and pulses drop
   always_comb begin
      w_state_nxt    = r_state;
      w_ir_nxt       = r_ir;
      w_step_nxt     = r_step;
      w_int_kind_nxt = r_int_kind;
      w_int_ack_nxt  = 1'b0;
      w_illegal_nxt  = 1'b0;
      w_nmi_clear    = 1'b0;
      if (RDY) begin
         case (r_state)
            ST_RESET_SEQ: begin
               // First cycle out of reset starts the reset microprogram
               w_state_nxt = ST_EXEC;
               w_step_nxt  = c_STEP_ONE;
            end
            ST_FETCH: begin
               w_state_nxt = ST_EXEC;
               w_step_nxt  = c_STEP_ONE;
               if (w_nmi_pending) begin
                  w_ir_nxt       = IR_W'(BRK_OPCODE);
                  w_int_kind_nxt = INT_NMI;
                  w_int_ack_nxt  = 1'b1;
                  w_nmi_clear    = 1'b1;
               end else if (!IRQ && !I_FLAG) begin
                  w_ir_nxt       = IR_W'(BRK_OPCODE);
                  w_int_kind_nxt = INT_IRQ;
                  w_int_ack_nxt  = 1'b1;
               end else begin
                  w_ir_nxt       = D_IN;
                  w_int_kind_nxt = INT_NONE;
               end
            end
            ST_EXEC: begin
               if (MC_END) begin
                  w_state_nxt = ST_FETCH;
                  w_step_nxt  = '0;
               end else if (r_step == c_STEP_MAX) begin
                  // Ran off the end of the step space without MC_END
                  w_state_nxt   = ST_FETCH;
                  w_step_nxt    = '0;
                  w_illegal_nxt = 1'b1;
               end else begin
                  w_step_nxt = r_step + c_STEP_ONE;
               end
            end
            default: begin
               w_state_nxt = ST_RESET_SEQ;
            end
         endcase
      end
   end

   // Outputs are pure decodes of registered state
   assign SYNC     = (r_state == ST_FETCH);
   assign MC_ADDR  = SYNC ? w_fetch_addr : {1'b0, r_ir, r_step};
   assign IR       = r_ir;
   assign STEP     = r_step;
   assign INT_KIND = r_int_kind;
   assign INT_ACK  = r_int_ack;
   assign ILLEGAL  = r_illegal;

endmodule : microcode_sequencer
`default_nettype wire
